cpu_bus_arbiter: RTL and testbench
==================================

// Module: cpu_bus_arbiter
// PURPOSE
//   Round-robin arbiter sharing the CPU control unit's single memory/ALU bus among NREQ requesters.
//   Requesters include the control FSM, a DMA engine and debug ports.
//   Grants one owner at a time, with a bounded hold time and a one-cycle bus-turnaround gap.
//   Sits between the requesters and the bus mux select; gnt_id drives the mux directly.
// PARAMETERS
//   NREQ      4   number of requesters, legal 2..8
//   HOLD_MAX  8   max cycles one owner may hold the bus before forced release, legal 2..255
// PORTS
//   clk       in   1              clock; all state updates on rising edge
//   rst       in   1              asynchronous, active-high reset
//   req       in   NREQ           per-requester request level; held high until done or grant loss
//   done      in   NREQ           per-requester end-of-transfer pulse; only done[owner] is honoured
//   gnt       out  NREQ           one-hot grant, registered; all-zero when no owner
//   gnt_id    out  $clog2(NREQ)   index of current owner; 0 when gnt==0
//   busy      out  1              1 while in GRANT or RELEASE
//   timeout   out  1              1-cycle pulse: owner was forcibly released
// BEHAVIOUR
//   Reset values: gnt=0, gnt_id=0, busy=0, timeout=0, state=IDLE, rr_ptr=0, hold_cnt=0.
//   rst asserted mid-grant: gnt drops asynchronously, with no RELEASE cycle and no timeout.
//   States:
//     IDLE:
//       - req==0: stay in IDLE.
//       - Otherwise pick the first set req at or after rr_ptr, scanning upward and wrapping NREQ-1 -> 0.
//       - Next edge: enter GRANT, gnt=onehot(pick), gnt_id=pick, hold_cnt=0.
//       - Latency is exactly 1 cycle from req sampled high to gnt high.
//     GRANT:
//       - Each cycle, hold_cnt is incremented, saturating at HOLD_MAX-1.
//       - Exit to RELEASE if done[owner]==1 or req[owner]==0.
//       - Else exit to RELEASE if hold_cnt==HOLD_MAX-1; this is a forced release.
//       - Otherwise stay in GRANT.
//       - Owner therefore holds gnt for at most HOLD_MAX cycles.
//       - done[owner] and the limit in the same cycle: normal release, no timeout.
//       - done/req changes of non-owners are ignored.
//     RELEASE:
//       - gnt=0, gnt_id=0, busy=1; lasts exactly one cycle (turnaround).
//       - timeout=1 in this cycle iff entered by forced release.
//       - rr_ptr = (owner+1) mod NREQ, wrapping from NREQ-1 to 0.
//       - Next edge: return to IDLE, where arbitration resumes.
//   Minimum spacing between two grants is 2 cycles (RELEASE + IDLE).
//   A requester left pending is served before the released owner is served again.
//   Fairness: any continuously asserting requester is granted within (NREQ-1)*(HOLD_MAX+2)+1 cycles.
//   Requester numbering:
//     - req bits at index >= NREQ do not exist.
//     - gnt_id never exceeds NREQ-1.
// CONFIGURATION
//   ARB_STATS_EN defined:
//     - Adds output timeout_cnt [7:0].
//     - Reset to 0; +1 on each timeout pulse; saturates at 255 (no wrap).
//     - Cleared only by rst.
//   ARB_STATS_EN undefined:
//     - Port and counter are absent.
//     - All other behaviour is identical.
// STRUCTURE
//   Shared package cpu_arb_pkg:
//     - arb_state_t enum: IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2.
//     - Function idw(n), returning $clog2(n).
//     - Constant ARB_TURNAROUND=1.
//   Sub-module cpu_arb_rr_pick (combinational):
//     - Inputs req and rr_ptr.
//     - Outputs valid and pick.
//     - This is the rotating priority encoder.
//   Top level holds the FSM, hold_cnt, rr_ptr and the optional stats counter.
// TESTING
//   1. Reset, then req=4'b0100 at cycle 0 -> gnt=4'b0100, gnt_id=2 at cycle 1.
//      Then done[2] pulsed at cycle 3 -> gnt=0 at cycle 4 (RELEASE), IDLE at cycle 5, timeout never 1.
//   2. req=4'b1111 held, each owner pulses done 2 cycles after its grant -> grant order 0,1,2,3,0 with a 2-cycle gap between grants.
//   3. req=4'b0001 held, never done, HOLD_MAX=8 -> gnt high for exactly 8 cycles; next cycle gnt=0 and timeout=1 for 1 cycle.
//      If req=4'b0011, the next grant is requester 1.
//   4. done[owner] asserted in the same cycle hold_cnt hits HOLD_MAX-1 -> normal release, timeout stays 0.
//      With ARB_STATS_EN, timeout_cnt is unchanged.
//   5. rst asserted mid-GRANT (owner 3) -> gnt=0 and busy=0 immediately.
//      After release with req=4'b1000 -> owner 3 granted (rr_ptr reset to 0).
//   6. ARB_STATS_EN: 300 forced timeouts -> timeout_cnt reads 255.
//      Non-owner done pulses -> no state change.

Source files
------------

// File: rtl/cpu_arb_pkg.sv
// Shared types and helpers for the CPU bus arbiter.
// State encoding, the index-width helper and the bus turnaround length.
package cpu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int ARB_TURNAROUND = 1;

  function automatic int idw(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/cpu_arb_rr_pick.sv
// Rotating priority encoder: first set request at or after rr_ptr, wrapping.
module cpu_arb_rr_pick
  import cpu_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic            valid,
  output logic [IW-1:0]   pick
);

  int          sum;
  logic [IW-1:0] idx;

  // Scan from the farthest offset down so the closest hit to rr_ptr wins.
  always_comb begin
    valid = |req;
    pick  = '0;
    sum   = 0;
    idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      sum = int'(rr_ptr) + i;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = IW'(sum);
      if (req[idx]) pick = idx;
    end
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Round-robin bus arbiter with bounded hold time and a one-cycle turnaround gap.
// Optional macro ARB_STATS_EN adds a saturating forced-release counter (timeout_cnt).
module cpu_bus_arbiter
  import cpu_arb_pkg::*;
#(
  parameter  int NREQ     = 4,
  parameter  int HOLD_MAX = 8,
  localparam int IW       = idw(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_id,
  output logic            busy,
  output logic            timeout
`ifdef ARB_STATS_EN
  ,
  output logic [7:0]      timeout_cnt
`endif
);

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX - 1);

  arb_state_t    state;
  logic [IW-1:0] rr_ptr;
  logic [7:0]    hold_cnt;
  logic          pick_valid;
  logic [IW-1:0] pick;
  logic [IW-1:0] next_ptr;
  logic          owner_end;
  logic          at_limit;
  logic          force_rel;

  cpu_arb_rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .pick   (pick)
  );

  // A normal end (done or dropped request) takes precedence over the hold limit.
  assign owner_end = done[gnt_id] | ~req[gnt_id];
  assign at_limit  = (hold_cnt == HOLD_LIM);
  assign force_rel = (state == GRANT) & at_limit & ~owner_end;
  assign next_ptr  = (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      hold_cnt <= '0;
      rr_ptr   <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state    <= GRANT;
            gnt      <= NREQ'(1) << pick;
            gnt_id   <= pick;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (!at_limit) hold_cnt <= hold_cnt + 8'd1;
          if (owner_end || at_limit) begin
            state   <= RELEASE;
            gnt     <= '0;
            gnt_id  <= '0;
            rr_ptr  <= next_ptr;
            timeout <= ~owner_end;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      timeout_cnt <= '0;
    else if (force_rel && timeout_cnt != 8'hFF)
      timeout_cnt <= timeout_cnt + 8'd1;
  end
`else
  logic unused_force_rel;
  assign unused_force_rel = force_rel;
`endif

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Scoreboard bench for cpu_bus_arbiter: a transaction-level model predicts
// each cycle's outputs, a separate monitor pops and compares them.
module tb_cpu_bus_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 8;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       tmo;
    logic [7:0] tcnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] done = '0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;
`ifdef ARB_STATS_EN
  logic [7:0] timeout_cnt;
`endif

  int checks = 0;
  int errors = 0;
  exp_t expQ[$];

  // Reference model: who owns the bus, for how many cycles, and whose turn is next.
  int mPhase = 0;
  int mOwner = 0;
  int mHeld  = 0;
  int mPtr   = 0;
  int mTcnt  = 0;
  bit mForced = 0;

  cpu_bus_arbiter #(.NREQ(N), .HOLD_MAX(HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
`ifdef ARB_STATS_EN
    ,
    .timeout_cnt (timeout_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic void cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endfunction

  function automatic void modelStep(input bit r, input logic [3:0] rq, input logic [3:0] dn);
    if (r) begin
      mPhase = 0; mOwner = 0; mHeld = 0; mPtr = 0; mForced = 0; mTcnt = 0;
      return;
    end
    case (mPhase)
      0: if (rq != 4'b0) begin
        for (int k = N - 1; k >= 0; k--)
          if (rq[(mPtr + k) % N]) mOwner = (mPtr + k) % N;
        mPhase = 1;
        mHeld  = 1;
      end
      1: begin
        if (dn[mOwner] || !rq[mOwner]) begin
          mPhase = 2; mForced = 0; mPtr = (mOwner + 1) % N;
        end else if (mHeld == HOLD) begin
          mPhase = 2; mForced = 1; mPtr = (mOwner + 1) % N;
          if (mTcnt < 255) mTcnt++;
        end else begin
          mHeld++;
        end
      end
      default: begin
        mPhase = 0; mForced = 0;
      end
    endcase
  endfunction

  function automatic exp_t modelOut();
    exp_t e;
    e.gnt  = (mPhase == 1) ? 4'(1 << mOwner) : 4'b0;
    e.id   = (mPhase == 1) ? 2'(mOwner) : 2'b0;
    e.busy = (mPhase != 0);
    e.tmo  = (mPhase == 2) && mForced;
    e.tcnt = 8'(mTcnt);
    return e;
  endfunction

  task automatic applyStimulus(input bit r, input logic [3:0] rq, input logic [3:0] dn);
    @(negedge clk);
    rst  = r;
    req  = rq;
    done = dn;
    modelStep(r, rq, dn);
    expQ.push_back(modelOut());
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("gnt", int'(gnt), int'(e.gnt));
    cmp("gnt_id", int'(gnt_id), int'(e.id));
    cmp("busy", int'(busy), int'(e.busy));
    cmp("timeout", int'(timeout), int'(e.tmo));
`ifdef ARB_STATS_EN
    cmp("timeout_cnt", int'(timeout_cnt), int'(e.tcnt));
`endif
  endtask

  // Monitor: one expected entry per active edge, compared 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    logic [3:0] rq;
    logic [3:0] dn;

    applyStimulus(1, 4'b0000, 4'b0000);
    applyStimulus(1, 4'b0000, 4'b0000);

    // Single request, owner ends with done three cycles after the request.
    applyStimulus(0, 4'b0100, 4'b0000);
    applyStimulus(0, 4'b0100, 4'b0000);
    applyStimulus(0, 4'b0100, 4'b0000);
    applyStimulus(0, 4'b0100, 4'b0100);
    for (int i = 0; i < 3; i++) applyStimulus(0, 4'b0000, 4'b0000);

    // All requesting; each owner signals done two cycles into its grant.
    for (int i = 0; i < 30; i++) begin
      dn = (mPhase == 1 && mHeld == 2) ? 4'(1 << mOwner) : 4'b0;
      applyStimulus(0, 4'b1111, dn);
    end
    for (int i = 0; i < 3; i++) applyStimulus(0, 4'b0000, 4'b0000);

    // Forced release of a lone requester, then a second requester gets the bus.
    for (int i = 0; i < 12; i++) applyStimulus(0, 4'b0001, 4'b0000);
    for (int i = 0; i < 14; i++) applyStimulus(0, 4'b0011, 4'b0000);
    for (int i = 0; i < 3; i++) applyStimulus(0, 4'b0000, 4'b0000);

    // done coincides with the hold limit: a normal release.
    for (int i = 0; i < 14; i++) begin
      dn = (mPhase == 1 && mHeld == HOLD) ? 4'(1 << mOwner) : 4'b0;
      applyStimulus(0, 4'b0100, dn);
    end
    for (int i = 0; i < 3; i++) applyStimulus(0, 4'b0000, 4'b0000);

    // Asynchronous reset in the middle of owner 3's grant.
    applyStimulus(1, 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++) applyStimulus(0, 4'b1000, 4'b0000);
    @(posedge clk);
    #2;
    cmp("pre_reset_gnt", int'(gnt), 8);
    rst = 1'b1;
    #1;
    cmp("async_rst_gnt", int'(gnt), 0);
    cmp("async_rst_busy", int'(busy), 0);
    cmp("async_rst_timeout", int'(timeout), 0);
    applyStimulus(1, 4'b1000, 4'b0000);
    for (int i = 0; i < 4; i++) applyStimulus(0, 4'b1000, 4'b0000);
    for (int i = 0; i < 3; i++) applyStimulus(0, 4'b0000, 4'b0000);

    // Randomised traffic with sticky requests and sporadic done pulses.
    rq = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < N; b++) begin
        if (rq[b]) begin
          if ($urandom_range(0, 9) == 0) rq[b] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          rq[b] = 1'b1;
        end
      end
      dn = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      if (mPhase == 1 && $urandom_range(0, 5) != 0) dn[mOwner] = 1'b0;
      applyStimulus(0, rq, dn);
    end

    // Many forced releases with non-owner done noise; exercises counter saturation.
    for (int i = 0; i < 300 * (HOLD + 2) + 20; i++)
      applyStimulus(0, 4'b0001, 4'($urandom_range(0, 7)) << 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 4'b0000, 4'b0000);

    @(posedge clk);
    #3;
    cmp("scoreboard_drained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
